// File: rtl/softmax_div_seq_if.sv
// Handshake bus for the softmax divider: input pair, result payload and status.
interface softmax_div_seq_if;
   localparam int unsigned XW = 8;
   localparam int unsigned YW = 32;

   logic          in_valid;
   logic          in_ready;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          out_valid;
   logic          out_ready;
   logic [XW-1:0] q;
   logic [YW-1:0] r;
   logic          ovf;
   logic          dz;
   logic          busy;

   modport master (
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, q, r, ovf, dz, busy
   );

   modport slave (
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, q, r, ovf, dz, busy
   );
endinterface

// File: rtl/softmax_div_seq.sv
// Sequential restoring divider: q = floor(x*2^31 / y), one quotient bit per cycle,
// with zero-divisor and quotient-saturation short paths.
module softmax_div_seq (
   input  logic             clk,
   input  logic             rst_n,
   softmax_div_seq_if.slave bus
);
   localparam int unsigned XW    = 8;
   localparam int unsigned YW    = 32;
   localparam int unsigned NW    = 39;
   localparam int unsigned CW    = 6;
   localparam int unsigned STEPS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [YW-1:0] y_q, y_d;
   logic [YW-1:0] rem_q, rem_d;
   logic [XW-1:0] dvd_q, dvd_d;
   logic [XW-1:0] quo_q, quo_d;
   logic [XW-1:0] q_q, q_d;
   logic [YW-1:0] r_q, r_d;
   logic          ovf_q, ovf_d;
   logic          dz_q, dz_d;

   logic [NW-1:0] n_c;
   logic          accept_c;
   logic          sat_c;
   logic [YW:0]   shl_c;
   logic [YW-1:0] diff_c;
   logic          bit_c;

   // Dividend is x scaled by 2^31; its top 31 bits seed the remainder, low 8 bits are shifted in.
   assign n_c      = {bus.x, 31'd0};
   assign accept_c = bus.in_valid && bus.in_ready;
   // N >= 256*y  <=>  floor(N/256) >= y, since y is an integer.
   assign sat_c    = (YW+1)'(n_c[NW-1:XW]) >= {1'b0, bus.y};

   // One restoring step over the 33-bit shifted partial remainder.
   assign shl_c  = {rem_q, dvd_q[XW-1]};
   assign bit_c  = shl_c >= {1'b0, y_q};
   assign diff_c = shl_c[YW-1:0] - y_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         y_q     <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         q_q     <= q_d;
         r_q     <= r_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      q_d     = q_q;
      r_d     = r_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (bus.y == '0) begin
                  state_d = DONE;
                  q_d     = '1;
                  r_d     = '0;
                  dz_d    = 1'b1;
                  ovf_d   = 1'b0;
               end else if (sat_c) begin
                  state_d = DONE;
                  q_d     = '1;
                  r_d     = '0;
                  dz_d    = 1'b0;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = '0;
                  y_d     = bus.y;
                  rem_d   = YW'(n_c[NW-1:XW]);
                  dvd_d   = n_c[XW-1:0];
                  quo_d   = '0;
               end
            end
         end
         CALC: begin
            rem_d = bit_c ? diff_c : shl_c[YW-1:0];
            quo_d = {quo_q[XW-2:0], bit_c};
            dvd_d = {dvd_q[XW-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               state_d = DONE;
               q_d     = quo_d;
               r_d     = rem_d;
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = rst_n && (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.q         = q_q;
   assign bus.r         = r_q;
   assign bus.ovf       = ovf_q;
   assign bus.dz        = dz_q;
endmodule

// File: tb/tb_softmax_div_seq.sv
// Scoreboard bench for softmax_div_seq: directed corner pairs plus randomized traffic.
module tb_softmax_div_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   bp_force = -1;

   typedef struct {
      logic [7:0]  q;
      logic [31:0] r;
      logic        ovf;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];

   softmax_div_seq_if bus ();

   softmax_div_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected end before 100000", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on N = x*2^31.
   function automatic exp_t model(input logic [7:0] xv, input logic [31:0] yv, input int acc);
      exp_t e;
      longint unsigned n;
      longint unsigned d;
      n = longint'(xv) * 64'd2147483648;
      d = 64'(yv);
      e.acc = acc;
      if (d == 0) begin
         e.q = 8'hFF; e.r = '0; e.ovf = 1'b0; e.dz = 1'b1; e.lat = 1;
      end else if (n >= 256 * d) begin
         e.q = 8'hFF; e.r = '0; e.ovf = 1'b1; e.dz = 1'b0; e.lat = 1;
      end else begin
         e.q = 8'(n / d); e.r = 32'(n % d); e.ovf = 1'b0; e.dz = 1'b0; e.lat = 9;
      end
      return e;
   endfunction

   task automatic send(input logic [7:0] xv, input logic [31:0] yv, output int acc);
      int t;
      t = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x = xv;
      bus.y = yv;
      while (!bus.in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout_cycles", 64'(t), 0);
         acc = -1;
      end else begin
         acc = cyc + 1;
         sb.push_back(model(xv, yv, acc));
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.x = 8'($urandom);
      bus.y = $urandom;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 64'(sb.size()), 0);
   endtask

   // Monitor: compares whatever the DUT presents against the head of the scoreboard.
   bit seen = 1'b0;
   bit post_hs = 1'b0;
   int wait_left = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
         post_hs = 1'b0;
         bus.out_ready = 1'b0;
      end else begin
         if (post_hs) begin
            check("post_hs_out_valid", 64'(bus.out_valid), 0);
            check("post_hs_in_ready", 64'(bus.in_ready), 1);
            post_hs = 1'b0;
         end
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", 64'(bus.out_valid), 0);
               bus.out_ready = 1'b1;
            end else begin
               exp_t e;
               e = sb[0];
               if (!seen) begin
                  seen = 1'b1;
                  check("latency_edges", 64'(cyc - e.acc + 1), 64'(e.lat));
                  wait_left = (bp_force >= 0) ? bp_force : int'($urandom_range(0, 3));
                  bp_force = -1;
               end
               check("q", 64'(bus.q), 64'(e.q));
               check("r", 64'(bus.r), 64'(e.r));
               check("ovf", 64'(bus.ovf), 64'(e.ovf));
               check("dz", 64'(bus.dz), 64'(e.dz));
               check("in_ready_while_done", 64'(bus.in_ready), 0);
               check("busy_while_done", 64'(bus.busy), 1);
               if (wait_left == 0) begin
                  bus.out_ready = 1'b1;
                  void'(sb.pop_front());
                  seen = 1'b0;
                  post_hs = 1'b1;
               end else begin
                  bus.out_ready = 1'b0;
                  wait_left--;
               end
            end
         end else begin
            bus.out_ready = 1'b0;
         end
      end
   end

   initial begin
      int a;
      logic [7:0]  xr;
      logic [31:0] yr;

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.x = '0;
      bus.y = '0;
      repeat (3) @(negedge clk);
      check("in_ready_in_reset", 64'(bus.in_ready), 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 1);
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_busy", 64'(bus.busy), 0);
      check("rst_q", 64'(bus.q), 0);
      check("rst_r", 64'(bus.r), 0);
      check("rst_ovf", 64'(bus.ovf), 0);
      check("rst_dz", 64'(bus.dz), 0);

      // Directed corners: exact power-of-two, off-by-one divisor, saturation, zero divisor, y = 1.
      send(8'd1, 32'h0100_0000, a);
      send(8'd1, 32'h0100_0001, a);
      send(8'd2, 32'h0100_0000, a);
      send(8'd77, 32'h0000_0000, a);
      send(8'd0, 32'h0000_0001, a);
      send(8'd1, 32'h0000_0001, a);
      send(8'd255, 32'hFFFF_FFFF, a);
      send(8'd0, 32'h0000_1234, a);
      wait_drain();

      // Backpressure: result must hold for three stalled cycles.
      bp_force = 3;
      send(8'd1, 32'h0100_0000, a);
      wait_drain();

      // Reset in the middle of CALC aborts the pair with no output.
      send(8'd3, 32'h1000_0000, a);
      while (cyc < a + 4) @(negedge clk);
      check("busy_in_calc", 64'(bus.busy), 1);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check("abort_out_valid", 64'(bus.out_valid), 0);
      check("abort_busy", 64'(bus.busy), 0);
      check("abort_in_ready", 64'(bus.in_ready), 0);
      check("abort_q", 64'(bus.q), 0);
      check("abort_r", 64'(bus.r), 0);
      check("abort_ovf", 64'(bus.ovf), 0);
      check("abort_dz", 64'(bus.dz), 0);
      rst_n = 1'b1;
      #1;
      check("abort_in_ready_after", 64'(bus.in_ready), 1);
      send(8'd0, 32'd5, a);
      wait_drain();

      // Randomized traffic with a mix of divisor magnitudes.
      for (int i = 0; i < 150; i++) begin
         xr = 8'($urandom);
         case ($urandom_range(0, 9))
            0:       yr = 32'd0;
            1:       yr = 32'd1;
            2, 3:    yr = $urandom >> $urandom_range(0, 31);
            default: yr = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         send(xr, yr, a);
      end
      wait_drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/softmax_div_seq.md
SOFTMAX_DIV_SEQ -- requirements
Module: softmax_div_seq

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous and active-low.
REQ-004 in_valid  in  1  dividend/divisor pair offered.
REQ-005 in_ready  out  1  block can accept a pair this cycle.
REQ-006 x  in  8  exponent-stage dividend numerator.
REQ-007 y  in  32  softmax denominator (sum of exponents).
REQ-008 out_valid  out  1  result held on q/r/ovf/dz.
REQ-009 out_ready  in  1  consumer takes result.
REQ-010 q  out  8  quotient.
REQ-011 r  out  32  remainder.
REQ-012 ovf  out  1  quotient saturated.
REQ-013 dz  out  1  divide by zero.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Arithmetic: N = x * 2^31 (39-bit); q = floor(N / y), r = N mod y, for y != 0 and N < 256*y.
REQ-016 Saturation: y != 0 and N >= 256*y -> q = 8'hFF, r = 0, ovf = 1, dz = 0.
REQ-017 Zero divisor: y == 0 -> q = 8'hFF, r = 0, dz = 1, ovf = 0; dz takes priority over ovf.
REQ-018 FSM states: IDLE, CALC, DONE.
REQ-019 in_ready = 1 only in IDLE; accept occurs on an edge with in_valid & in_ready.
REQ-020 On accept, x and y are registered; later input changes have no effect.
REQ-021 Accept with y == 0 or saturation: IDLE -> DONE; out_valid = 1 after the accept edge (1-cycle latency).
REQ-022 Other accepts: IDLE -> CALC; the 6-bit iteration counter is loaded to 0.
REQ-023 CALC computes one restoring-division step per cycle, MSB first, over a 33-bit partial remainder.
REQ-024 Step k (k = 0..7) produces quotient bit 7-k: partial remainder shifted left by one with the next dividend bit; subtract y if >= y.
REQ-025 After exactly 8 CALC edges: CALC -> DONE.
REQ-026 Normal-path latency: out_valid rises 9 edges after the accept edge.
REQ-027 DONE: out_valid = 1 and q/r/ovf/dz are stable; they hold indefinitely while out_ready = 0.
REQ-028 DONE with out_ready = 1: -> IDLE; out_valid = 0 next cycle.
REQ-029 No new accept in the same cycle as an output handshake; in_ready rises the cycle after.
REQ-030 q, r, ovf and dz change only on transition into DONE; elsewhere they hold their last values.
REQ-031 x = 0 with y != 0 still takes the full 8 CALC cycles: q = 0, r = 0.
REQ-032 Maximum legal case y = 1: N < 256 only when x = 0; otherwise ovf = 1.

Reset
REQ-033 rst_n = 0 at an edge forces IDLE; counter 0; in_ready = 1 (once rst_n = 1); out_valid = 0; busy = 0; q = 0; r = 0; ovf = 0; dz = 0.
REQ-034 Reset in CALC or DONE aborts the operation; no out_valid pulse for the aborted pair.
REQ-035 in_ready = 0 while rst_n = 0.

Verification
REQ-036 x=1, y=32'h0100_0000 -> 9 edges after accept: out_valid=1, q=8'h80, r=0, ovf=0, dz=0.
REQ-037 x=1, y=32'h0100_0001 -> q=8'h7F, r=32'h00FF_FF81.
REQ-038 x=2, y=32'h0100_0000 -> out_valid one edge after accept; q=8'hFF, r=0, ovf=1. Also y=0 -> q=8'hFF, dz=1, ovf=0, same latency.
REQ-039 Backpressure: normal result with out_ready=0 for 3 cycles -> out_valid and outputs stable throughout; in_ready=0; released on the first out_ready=1 edge.
REQ-040 Reset mid-operation: rst_n=0 at CALC step 4 -> next cycle IDLE, all outputs zero. A following x=0, y=5 -> q=0, r=0 after 9 edges.
REQ-041 Back-to-back randomized pairs vs a reference model of REQ-015..017 -> all q/r/ovf/dz match, in order, none dropped or duplicated.
